// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a little-endian word image from a byte stream into instruction RAM
// Optional LOADER_CHECKSUM_EN: trailing XOR checksum byte validates the payload.
module program_loader #(
  parameter int MEMORY_DEPTH = 256,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Busy,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error
);

  localparam logic [16:0] DEPTH = 17'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHK
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    ready_q, ready_d;
  logic                    we_q, we_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              chk_q, chk_d;
`endif

  logic        take;
  logic        end_load;
  logic [15:0] n_words;

  assign take    = ByteValid && ready_q;
  assign n_words = {len_q[15:8], ByteIn};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = done_q;
    error_d  = error_q;
    end_load = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          addr_d  = '0;
          cnt_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = 8'h00;
`endif
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (take) begin
          len_d[15:8] = ByteIn;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (take) begin
          len_d = n_words;
          if ({1'b0, n_words} > DEPTH) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (n_words == 16'd0) begin
            end_load = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          data_d[{cnt_q, 3'b000} +: 8] = ByteIn;
`ifdef LOADER_CHECKSUM_EN
          chk_d = chk_q ^ ByteIn;
`endif
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + DATA_WIDTH'(4);
        len_d  = len_q - 16'd1;
        if (len_q == 16'd1) end_load = 1'b1;
        else                state_d  = S_DATA;
      end
      S_CHK: begin
        if (take) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef LOADER_CHECKSUM_EN
          if (ByteIn == chk_q) done_d  = 1'b1;
          else                 error_d = 1'b1;
`else
          done_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Last word written (or empty image): either await the checksum or finish now.
    if (end_load) begin
`ifdef LOADER_CHECKSUM_EN
      state_d = S_CHK;
`else
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
`endif
    end

    ready_d = (state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK});
    we_d    = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      ready_q <= ready_d;
      we_q    <= we_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign ByteReady    = ready_q;
  assign WriteEnable  = we_q;
  assign WriteAddress = addr_q;
  assign WriteData    = data_q;
  assign Busy         = busy_q;
  assign CpuHold      = busy_q;
  assign Done         = done_q;
  assign Error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
// Honors LOADER_CHECKSUM_EN to match the DUT build.
module tb_program_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  ByteIn = 8'h00;
  logic        ByteValid = 1'b0;
  logic        ByteReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        Busy;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
    .WriteData(WriteData), .Busy(Busy), .CpuHold(CpuHold), .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (WriteEnable) begin
      got_addr.push_back(WriteAddress);
      got_data.push_back(WriteData);
      check("we_single_cycle", 32'(prev_we), 32'd0);
      check("ready_low_in_write", 32'(ByteReady), 32'd0);
    end
    prev_we = WriteEnable;
  end

  // Reference model: what a byte image should produce, derived from the stream format.
  logic [7:0]  stim[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done;
  logic        exp_err;
  logic        err_early;

  function automatic void model(input logic [7:0] s[$]);
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = int'({s[0], s[1]});
    x = 8'h00;
    if (n > DEPTH) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
      return;
    end
    for (int w = 0; w < n; w++) begin
      logic [31:0] word;
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        word = word | (32'(s[2 + 4*w + k]) << (8*k));
        x    = x ^ s[2 + 4*w + k];
      end
      exp_addr.push_back(32'(4*w));
      exp_data.push_back(word);
    end
`ifdef LOADER_CHECKSUM_EN
    exp_done = (s[2 + 4*n] == x);
    exp_err  = !exp_done;
`else
    exp_done = 1'b1;
    exp_err  = 1'b0;
`endif
  endfunction

  task automatic build(input int n, input bit bad);
    logic [7:0] x;
    x = 8'h00;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    if (n > DEPTH) return;
    for (int i = 0; i < 4*n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      x = x ^ b;
      stim.push_back(b);
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
`else
    if (bad) x = 8'h00;
`endif
  endtask

  task automatic do_start(input string tag);
    @(negedge clk) Start = 1'b1;
    @(negedge clk) Start = 1'b0;
    check({tag, "_busy"}, 32'(Busy), 32'd1);
    check({tag, "_hold"}, 32'(CpuHold), 32'd1);
    check({tag, "_ready"}, 32'(ByteReady), 32'd1);
    check({tag, "_done_clr"}, 32'(Done), 32'd0);
    check({tag, "_err_clr"}, 32'(Error), 32'd0);
  endtask

  task automatic run_load(input int gap_pct, input bit starts, input string tag);
    int idx;
    int budget;
    idx = 0;
    budget = 0;
    model(stim);
    got_addr.delete();
    got_data.delete();
    do_start(tag);
    while (idx < stim.size() && budget < 20000) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        ByteValid = 1'b0;
      end else begin
        ByteValid = 1'b1;
        ByteIn    = stim[idx];
      end
      Start = starts && Busy && ($urandom_range(0, 9) == 0);
      if (ByteValid && ByteReady) idx++;
      @(negedge clk);
      budget++;
    end
    ByteValid = 1'b0;
    Start     = 1'b0;
    err_early = Error;
    check({tag, "_feed_timeout"}, 32'(budget < 20000), 32'd1);
    budget = 0;
    while (Busy && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_busy_timeout"}, 32'(budget < 100), 32'd1);
    check({tag, "_done"}, 32'(Done), 32'(exp_done));
    check({tag, "_error"}, 32'(Error), 32'(exp_err));
    check({tag, "_busy_end"}, 32'(Busy), 32'd0);
    check({tag, "_hold_end"}, 32'(CpuHold), 32'd0);
    check({tag, "_ready_end"}, 32'(ByteReady), 32'd0);
    check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, got_addr[i], exp_addr[i]);
      check({tag, "_data"}, got_data[i], exp_data[i]);
    end
  endtask

  initial begin
    int idx;
    int b;

    // Reset held with Start/ByteValid active.
    Start = 1'b1;
    ByteValid = 1'b1;
    ByteIn = 8'hAA;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hold", 32'(CpuHold), 32'd0);
    check("rst_ready", 32'(ByteReady), 32'd0);
    check("rst_we", 32'(WriteEnable), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_addr", WriteAddress, 32'd0);
    check("rst_data", WriteData, 32'd0);
    Start = 1'b0;
    ByteValid = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", 32'(Busy), 32'd0);
    check("post_rst_nowrite", 32'(got_addr.size()), 32'd0);

    // Directed two-word image.
    stim = '{8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h2A);
`endif
    run_load(0, 1'b0, "dir2");
    if (got_data.size() >= 2) begin
      check("dir2_w0", got_data[0], 32'h12345678);
      check("dir2_w1", got_data[1], 32'hDEADBEEF);
      check("dir2_a1", got_addr[1], 32'h4);
    end

    // Oversize count: error the cycle after LEN_LO.
    build(257, 1'b0);
    run_load(0, 1'b0, "ovf");
    check("ovf_err_next_cycle", 32'(err_early), 32'd1);

    build(0, 1'b0);
    run_load(0, 1'b0, "empty");

    build(DEPTH, 1'b0);
    run_load(0, 1'b0, "full");

    for (int i = 0; i < 12; i++) begin
      build($urandom_range(0, 6), $urandom_range(0, 3) == 0);
      run_load(35, 1'b1, "rand");
    end

    // Reset after two data bytes, then a clean load from address 0.
    build(4, 1'b0);
    got_addr.delete();
    got_data.delete();
    do_start("midrst");
    idx = 0;
    b = 0;
    while (idx < 4 && b < 50) begin
      ByteValid = 1'b1;
      ByteIn = stim[idx];
      if (ByteReady) idx++;
      @(negedge clk);
      b++;
    end
    ByteValid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_ready", 32'(ByteReady), 32'd0);
    check("midrst_hold", 32'(CpuHold), 32'd0);
    check("midrst_addr", WriteAddress, 32'd0);
    check("midrst_data", WriteData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_nowrite", 32'(got_addr.size()), 32'd0);
    build(3, 1'b0);
    run_load(20, 1'b0, "after_rst");

`ifdef LOADER_CHECKSUM_EN
    stim = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(0, 1'b0, "chk_bad");
    check("chk_bad_err", 32'(Error), 32'd1);
    stim = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_load(0, 1'b0, "chk_good");
    check("chk_good_done", 32'(Done), 32'd1);
    if (got_data.size() >= 1) check("chk_good_word", got_data[0], 32'h04030201);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
